ssb_bus_arbiter: RTL and testbench
==================================

// Module: ssb_bus_arbiter
// PURPOSE
// - Arbitrates the shared system bus (SSB) between three hosts: debug SBA (host 0), Ibex instr (host 1), Ibex data (host 2).
// - Drives one request per cycle to the SRAM/debug-memory decode and returns the 1-cycle read response to the owning host.
// - Debug has fixed priority; instr/data alternate round-robin; optional starvation guard stops debug traffic locking out the core.
// PARAMETERS
// - AddrWidth    32  address width of all host and SSB address buses
// - DataWidth    32  data width; byte enables are DataWidth/8 bits
// - StarveLimit  8   debug-win cycles tolerated against a waiting core host (>=1; only with SSB_ARB_STARVE_GUARD_EN)
// PORTS
// - clk_sys_i     in   1          system clock
// - rst_sys_i     in   1          synchronous reset, active-high
// - hN_req_i      in   1          host N request (N = 0 dbg, 1 instr, 2 data)
// - hN_addr_i     in   AddrWidth  host N address
// - hN_we_i       in   1          host N write enable (h1_we_i absent; instr is read-only)
// - hN_be_i       in   DW/8       host N byte enables (h1 absent)
// - hN_wdata_i    in   DataWidth  host N write data (h1 absent)
// - hN_gnt_o      out  1          host N grant, combinational, same cycle as request
// - hN_rvalid_o   out  1          host N response valid, 1 cycle after its grant
// - ssb_req_o     out  1          SSB request
// - ssb_addr_o    out  AddrWidth  SSB address
// - ssb_we_o      out  1          SSB write enable
// - ssb_be_o      out  DW/8       SSB byte enables
// - ssb_wdata_o   out  DataWidth  SSB write data
// - arb_owner_o   out  2          host owning the response in flight (0/1/2); 3 = none
// - arb_starve_o  out  1          pulse: guard forced a core grant over debug
// BEHAVIOUR
// - Reset (rst_sys_i=1 at a clock edge): rr_q=0 (instr preferred), owner_q=3, all hN_rvalid_o=0, starve_cnt_q=0.
// - While rst_sys_i=1: all hN_gnt_o=0, ssb_req_o=0, SSB payload outputs 0, regardless of requests.
// - Exactly one hN_gnt_o high per cycle when any hN_req_i is high; none otherwise. ssb_req_o = OR of grants.
// - SSB payload muxed from the granted host; zero when no grant; for host 1 we=0, be=0, wdata=0.
// - Priority: h0 if requesting (unless guard fires); else if h1 and h2 both request, rr_q picks (0: h1, 1: h2); else the lone requester.
// - rr_q update: grant to h1 -> 1, grant to h2 -> 0; h0 grant or idle -> hold.
// - Response: owner_q <= granted index (3 if none); hN_rvalid_o = (owner_q==N) registered, i.e. 1-cycle latency, one-hot.
// - Back-to-back grants every cycle allowed; hosts read ssb_rdata downstream on their own rvalid.
// - Writes also produce rvalid (acknowledge) 1 cycle later.
// - Reset mid-transaction: pending rvalid is dropped (owner_q=3), no response ever issued for that grant.
// CONFIGURATION
// - Macro SSB_ARB_STARVE_GUARD_EN defined:
//   - starve_cnt_q increments (saturating at StarveLimit) each cycle h0 is granted while h1 or h2 requests.
//   - Clears on any h1/h2 grant.
//   - When starve_cnt_q==StarveLimit and h1|h2 requests: the RR-selected core host wins over h0 that cycle.
//   - arb_starve_o=1 for that cycle; counter then clears.
// - Not defined: strict h0 priority, no counter flops, arb_starve_o tied 0.
// TESTING
// - Reset: hold rst_sys_i=1 with all reqs high 3 cycles -> no gnt, ssb_req_o=0, rvalids 0, arb_owner_o=3.
// - Single host: h2 write addr 0x100, be 4'hF, wdata 0xDEADBEEF -> h2_gnt_o same cycle, SSB payload matches, h2_rvalid_o next cycle only.
// - RR: h1,h2 requesting continuously 6 cycles from reset -> grants h1,h2,h1,h2,h1,h2; rvalids follow one cycle later, one-hot.
// - Debug priority: h0,h1,h2 all request -> h0 granted; guard off -> h0 wins indefinitely, arb_starve_o=0.
// - Guard (StarveLimit=8): h0,h1 held high -> h0 granted cycles 0..7, h1 granted cycle 8 with arb_starve_o=1, h0 again cycle 9.
// - Reset mid-op: grant h1 at cycle N, rst_sys_i=1 at N+1 edge -> no h1_rvalid_o; first post-reset h1/h2 tie goes to h1.

Source files
------------

// File: rtl/ssb_bus_arbiter.sv
// Three-host arbiter for the shared system bus: debug (h0) has fixed priority, instr (h1) and data (h2) round-robin.
// Optional starvation guard against debug lockout is enabled by defining SSB_ARB_STARVE_GUARD_EN.
module ssb_bus_arbiter #(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32,
  parameter int StarveLimit = 8
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   h0_req_i,
  input  logic [AddrWidth-1:0]   h0_addr_i,
  input  logic                   h0_we_i,
  input  logic [DataWidth/8-1:0] h0_be_i,
  input  logic [DataWidth-1:0]   h0_wdata_i,
  output logic                   h0_gnt_o,
  output logic                   h0_rvalid_o,
  input  logic                   h1_req_i,
  input  logic [AddrWidth-1:0]   h1_addr_i,
  output logic                   h1_gnt_o,
  output logic                   h1_rvalid_o,
  input  logic                   h2_req_i,
  input  logic [AddrWidth-1:0]   h2_addr_i,
  input  logic                   h2_we_i,
  input  logic [DataWidth/8-1:0] h2_be_i,
  input  logic [DataWidth-1:0]   h2_wdata_i,
  output logic                   h2_gnt_o,
  output logic                   h2_rvalid_o,
  output logic                   ssb_req_o,
  output logic [AddrWidth-1:0]   ssb_addr_o,
  output logic                   ssb_we_o,
  output logic [DataWidth/8-1:0] ssb_be_o,
  output logic [DataWidth-1:0]   ssb_wdata_o,
  output logic [1:0]             arb_owner_o,
  output logic                   arb_starve_o
);

  localparam int BeW = DataWidth / 8;

  localparam logic [1:0] OWN_H0   = 2'd0;
  localparam logic [1:0] OWN_H1   = 2'd1;
  localparam logic [1:0] OWN_H2   = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  logic       rr_q, rr_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] sel;
  logic       core_req;
  logic       starve_fire;

  assign core_req = h1_req_i | h2_req_i;

`ifdef SSB_ARB_STARVE_GUARD_EN
  localparam int CntW = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_fire = !rst_sys_i && h0_req_i && core_req && (starve_cnt_q == CntMax);

  // Saturates while debug wins against a waiting core host; any core grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (sel == OWN_H1 || sel == OWN_H2) begin
      starve_cnt_d = '0;
    end else if (sel == OWN_H0 && core_req && starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic [31:0] starve_limit_unused;
  assign starve_limit_unused = 32'(StarveLimit);
  assign starve_fire = 1'b0;
`endif

  assign arb_starve_o = starve_fire;

  always_comb begin
    sel = OWN_NONE;
    if (!rst_sys_i) begin
      if (h0_req_i && !starve_fire) begin
        sel = OWN_H0;
      end else if (h1_req_i && h2_req_i) begin
        sel = rr_q ? OWN_H2 : OWN_H1;
      end else if (h1_req_i) begin
        sel = OWN_H1;
      end else if (h2_req_i) begin
        sel = OWN_H2;
      end
    end
  end

  assign h0_gnt_o  = (sel == OWN_H0);
  assign h1_gnt_o  = (sel == OWN_H1);
  assign h2_gnt_o  = (sel == OWN_H2);
  assign ssb_req_o = h0_gnt_o | h1_gnt_o | h2_gnt_o;

  // Instr host is read-only, so its write-side payload stays zero.
  always_comb begin
    ssb_addr_o  = '0;
    ssb_we_o    = 1'b0;
    ssb_be_o    = '0;
    ssb_wdata_o = '0;
    case (sel)
      OWN_H0: begin
        ssb_addr_o  = h0_addr_i;
        ssb_we_o    = h0_we_i;
        ssb_be_o    = h0_be_i;
        ssb_wdata_o = h0_wdata_i;
      end
      OWN_H1: begin
        ssb_addr_o = h1_addr_i;
      end
      OWN_H2: begin
        ssb_addr_o  = h2_addr_i;
        ssb_we_o    = h2_we_i;
        ssb_be_o    = h2_be_i;
        ssb_wdata_o = h2_wdata_i;
      end
      default: begin
        ssb_be_o = {BeW{1'b0}};
      end
    endcase
  end

  always_comb begin
    rr_d    = rr_q;
    owner_d = sel;
    if (sel == OWN_H1) begin
      rr_d = 1'b1;
    end else if (sel == OWN_H2) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rr_q    <= 1'b0;
      owner_q <= OWN_NONE;
    end else begin
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // A response pending when reset arrives is suppressed, not delivered late.
  assign h0_rvalid_o = (owner_q == OWN_H0) && !rst_sys_i;
  assign h1_rvalid_o = (owner_q == OWN_H1) && !rst_sys_i;
  assign h2_rvalid_o = (owner_q == OWN_H2) && !rst_sys_i;
  assign arb_owner_o = owner_q;

endmodule

// File: tb/tb_ssb_bus_arbiter.sv
// Directed self-checking bench for ssb_bus_arbiter (StarveLimit = 8).
// Guard expectations follow SSB_ARB_STARVE_GUARD_EN as defined for this build.
module tb_ssb_bus_arbiter;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i;
  logic        h0_req_i, h0_we_i, h0_gnt_o, h0_rvalid_o;
  logic [31:0] h0_addr_i, h0_wdata_i;
  logic [3:0]  h0_be_i;
  logic        h1_req_i, h1_gnt_o, h1_rvalid_o;
  logic [31:0] h1_addr_i;
  logic        h2_req_i, h2_we_i, h2_gnt_o, h2_rvalid_o;
  logic [31:0] h2_addr_i, h2_wdata_i;
  logic [3:0]  h2_be_i;
  logic        ssb_req_o, ssb_we_o, arb_starve_o;
  logic [31:0] ssb_addr_o, ssb_wdata_o;
  logic [3:0]  ssb_be_o;
  logic [1:0]  arb_owner_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_sys_i = ~clk_sys_i;

  ssb_bus_arbiter #(.AddrWidth(32), .DataWidth(32), .StarveLimit(8)) dut (
    .clk_sys_i(clk_sys_i), .rst_sys_i(rst_sys_i),
    .h0_req_i(h0_req_i), .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i),
    .h0_wdata_i(h0_wdata_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o),
    .h1_req_i(h1_req_i), .h1_addr_i(h1_addr_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o),
    .h2_req_i(h2_req_i), .h2_addr_i(h2_addr_i), .h2_we_i(h2_we_i), .h2_be_i(h2_be_i),
    .h2_wdata_i(h2_wdata_i), .h2_gnt_o(h2_gnt_o), .h2_rvalid_o(h2_rvalid_o),
    .ssb_req_o(ssb_req_o), .ssb_addr_o(ssb_addr_o), .ssb_we_o(ssb_we_o), .ssb_be_o(ssb_be_o),
    .ssb_wdata_o(ssb_wdata_o), .arb_owner_o(arb_owner_o), .arb_starve_o(arb_starve_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  initial begin
    logic exp_h0;

    rst_sys_i = 1'b1;
    h0_req_i = 1'b1; h0_addr_i = 32'h400; h0_we_i = 1'b0; h0_be_i = 4'h3; h0_wdata_i = 32'hA5A5_0000;
    h1_req_i = 1'b1; h1_addr_i = 32'h200;
    h2_req_i = 1'b1; h2_addr_i = 32'h300; h2_we_i = 1'b1; h2_be_i = 4'hC; h2_wdata_i = 32'h1234_5678;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b000);
      chk("rst_ssb_req", ssb_req_o, 1'b0);
      chk("rst_ssb_addr", ssb_addr_o, 32'h0);
      chk("rst_ssb_wdata", ssb_wdata_o, 32'h0);
      chk("rst_rvalid", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b000);
      chk("rst_owner", arb_owner_o, 2'd3);
    end

    rst_sys_i = 1'b0;
    h0_req_i = 1'b0; h1_req_i = 1'b0; h2_req_i = 1'b0;
    tick();
    chk("idle_gnt", {h0_gnt_o, h1_gnt_o, h2_gnt_o, ssb_req_o}, 4'b0000);
    chk("idle_owner", arb_owner_o, 2'd3);

    // Lone data-host write.
    h2_req_i = 1'b1; h2_addr_i = 32'h100; h2_we_i = 1'b1; h2_be_i = 4'hF; h2_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("single_gnt", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b001);
    chk("single_ssb_req", ssb_req_o, 1'b1);
    chk("single_addr", ssb_addr_o, 32'h100);
    chk("single_we", ssb_we_o, 1'b1);
    chk("single_be", ssb_be_o, 4'hF);
    chk("single_wdata", ssb_wdata_o, 32'hDEAD_BEEF);
    chk("single_no_early_rvalid", h2_rvalid_o, 1'b0);
    tick();
    h2_req_i = 1'b0;
    #1;
    chk("single_rvalid", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b001);
    chk("single_owner", arb_owner_o, 2'd2);
    chk("single_gnt_drop", h2_gnt_o, 1'b0);
    tick();
    chk("single_rvalid_once", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b000);

    // Instr/data round-robin; last grant was h2 so h1 is preferred.
    h1_req_i = 1'b1; h1_addr_i = 32'h200;
    h2_req_i = 1'b1; h2_addr_i = 32'h300; h2_we_i = 1'b1; h2_be_i = 4'hC; h2_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("rr_gnt_h1", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b010);
        chk("rr_h1_addr", ssb_addr_o, 32'h200);
        chk("rr_h1_payload", {ssb_we_o, ssb_be_o, ssb_wdata_o}, 37'h0);
      end else begin
        chk("rr_gnt_h2", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b001);
        chk("rr_h2_addr", ssb_addr_o, 32'h300);
        chk("rr_h2_payload", {ssb_we_o, ssb_be_o, ssb_wdata_o}, {1'b1, 4'hC, 32'h1234_5678});
      end
      tick();
      chk("rr_rvalid", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, (i % 2 == 0) ? 3'b010 : 3'b001);
      chk("rr_owner", arb_owner_o, (i % 2 == 0) ? 2'd1 : 2'd2);
    end

    // Debug against both core hosts.
    h0_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef SSB_ARB_STARVE_GUARD_EN
      exp_h0 = (i != 8);
`else
      exp_h0 = 1'b1;
`endif
      #1;
      chk("dbg_gnt", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, exp_h0 ? 3'b100 : 3'b010);
      chk("dbg_starve", arb_starve_o, !exp_h0);
      chk("dbg_addr", ssb_addr_o, exp_h0 ? 32'h400 : 32'h200);
      tick();
    end
    h0_req_i = 1'b0; h1_req_i = 1'b0; h2_req_i = 1'b0;
    #1;
    chk("dbg_rvalid", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b100);
    chk("dbg_owner", arb_owner_o, 2'd0);
    chk("dbg_idle_gnt", ssb_req_o, 1'b0);

    // Reset lands while an instr response is pending.
    tick();
    h1_req_i = 1'b1;
    #1;
    chk("midrst_gnt", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b010);
    tick();
    h1_req_i = 1'b0;
    rst_sys_i = 1'b1;
    #1;
    chk("midrst_rvalid_drop", h1_rvalid_o, 1'b0);
    tick();
    chk("midrst_rvalid_after", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b000);
    chk("midrst_owner", arb_owner_o, 2'd3);
    rst_sys_i = 1'b0;
    h1_req_i = 1'b1; h2_req_i = 1'b1;
    #1;
    chk("postrst_tie", {h0_gnt_o, h1_gnt_o, h2_gnt_o}, 3'b010);
    tick();
    chk("postrst_rvalid", {h0_rvalid_o, h1_rvalid_o, h2_rvalid_o}, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
